// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 8N1 UART receive front end.
// Synchronizes the serial line, qualifies the start bit at half a bit time,
// samples eight data bits LSB-first at mid-bit and checks the stop bit.
// Good frames are delivered as a byte plus a one-cycle valid strobe.
// A low stop bit gives a one-cycle framing-error strobe. The receiver then
// waits in LINE_BREAK until the line returns high.
//
// Handshake: oRX_VALID is a one-cycle push strobe with no ready. oRX_DATA is
// updated on the same cycle and then holds until the next good frame.
// oRX_VALID and oRX_FERR are mutually exclusive and fire at most once per
// frame.
module uart_rx_sampler #(
  parameter int BAUD_MAX = 10414,
  parameter int HALF_MAX = 5207
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iRX,
  output logic [7:0] oRX_DATA,
  output logic       oRX_VALID,
  output logic       oRX_FERR,
  output logic       oRX_BUSY,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    STOP       = 3'd3,
    LINE_BREAK = 3'd4
  } state_t;

  localparam logic [13:0] BAUD_CNT = 14'(BAUD_MAX);
  localparam logic [13:0] HALF_CNT = 14'(HALF_MAX);

  state_t      state, state_n;
  logic [13:0] cnt, cnt_n;
  logic [2:0]  idx, idx_n;
  logic [7:0]  shift, shift_n;
  logic [7:0]  data_n;
  logic        valid_n, ferr_n;
  logic        rx_meta, rx_s;

  assign dbg_state = state;

  // Two-flop synchronizer. It resets to the idle-high line level.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= iRX;
      rx_s    <= rx_meta;
    end
  end

  // Next-state, counter, shift and strobe decisions. All are based on rx_s.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 14'd1;
    idx_n   = idx;
    shift_n = shift;
    data_n  = oRX_DATA;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      IDLE: begin
        // The counter is held at zero so it never free-runs while idle.
        cnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (cnt == HALF_CNT) begin
          cnt_n = '0;
          if (!rx_s) begin
            state_n = DATA;
            idx_n   = 3'd0;
          end else begin
            // The low pulse was too short to be a start bit.
            state_n = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt == BAUD_CNT) begin
          cnt_n   = '0;
          shift_n = {rx_s, shift[7:1]};
          if (idx == 3'd7) state_n = STOP;
          else             idx_n   = idx + 3'd1;
        end
      end
      STOP: begin
        if (cnt == BAUD_CNT) begin
          cnt_n = '0;
          if (rx_s) begin
            data_n  = shift;
            valid_n = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = LINE_BREAK;
          end
        end
      end
      LINE_BREAK: begin
        // A line held low must go high again before a new start bit counts.
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs. BUSY is derived from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= 8'h00;
      oRX_DATA  <= 8'h00;
      oRX_VALID <= 1'b0;
      oRX_FERR  <= 1'b0;
      oRX_BUSY  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shift     <= shift_n;
      oRX_DATA  <= data_n;
      oRX_VALID <= valid_n;
      oRX_FERR  <= ferr_n;
      oRX_BUSY  <= (state_n != IDLE);
    end
  end

endmodule

// File: doc/uart_rx_sampler.md
# uart_rx_sampler

UART receiver front end: synchronizes the asynchronous serial input, detects and qualifies the start bit, samples 8 data bits LSB-first at mid-bit, and checks the stop bit (8N1). It is the receive counterpart of the TX baud generator and TX path, running on the same system clock with the same per-bit count. Each good frame is presented as a byte with a one-cycle valid strobe to the downstream RX FIFO.

## Interface
- BAUD_MAX, 10414: clocks per bit minus 1 (bit period = BAUD_MAX+1 clk); same value as the TX side; legal range 3..16383.
- HALF_MAX, 5207: start-bit qualification point, clocks minus 1; must satisfy 1 ≤ HALF_MAX < BAUD_MAX, normally BAUD_MAX/2.
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- iRX  input  1  asynchronous serial line, idle high.
- oRX_DATA  output  8  last good received byte; holds until the next good frame.
- oRX_VALID  output  1  one-cycle pulse, oRX_DATA updated in the same cycle.
- oRX_FERR  output  1  one-cycle pulse on a bad (low) stop bit.
- oRX_BUSY  output  1  high in every state except IDLE.

## Operation
- Input: 2-flop synchronizer on iRX, output rx_s; both flops reset to 1. All decisions use rx_s only.
- Counter: 14-bit cnt, cleared on every state transition, increments by 1 each clk otherwise; compare values never exceed BAUD_MAX, so no wrap.
- Bit index: 3-bit idx, 0..7.
- States: IDLE, START, DATA, STOP, BREAK.
  - IDLE: rx_s==0 → START.
  - START: at cnt==HALF_MAX: rx_s==0 → DATA (idx=0); rx_s==1 → IDLE (glitch rejected, no pulses).
  - DATA: at cnt==BAUD_MAX: shift register <= {rx_s, shift[7:1]}; idx==7 → STOP, else idx+1.
  - STOP: at cnt==BAUD_MAX: rx_s==1 → oRX_DATA<=shift, oRX_VALID=1, → IDLE; rx_s==0 → oRX_FERR=1, oRX_DATA unchanged, → BREAK.
  - BREAK: wait for rx_s==1 → IDLE (prevents a held-low line from being taken as back-to-back start bits).
- Reset values: state IDLE, cnt 0, idx 0, shift 8'h00, oRX_DATA 8'h00, oRX_VALID 0, oRX_FERR 0, oRX_BUSY 0, synchronizer 1/1.
- reset asserted mid-frame: next edge forces all reset values; partial byte discarded, no pulse.
- oRX_VALID and oRX_FERR never assert in the same cycle; each at most once per frame.

## Timing
- Synchronizer latency: 2 clk from iRX edge to rx_s.
- Let T0 = first edge with rx_s==0 in IDLE (state becomes START at T0).
- Start qualified at T0+HALF_MAX+1; data bit k sampled at T0+HALF_MAX+1+(k+1)(BAUD_MAX+1), k=0..7; stop sampled at T0+HALF_MAX+1+9(BAUD_MAX+1).
- oRX_VALID/oRX_FERR are registered: high for the single cycle after the stop-sample edge.
- IDLE re-entered on the same edge as the pulse; a new start bit sampled low in the next cycle is accepted (zero dead time), supporting back-to-back frames at full baud.
- oRX_BUSY is registered from state: rises the cycle after T0, falls with the return to IDLE.

## Test plan
- BAUD_MAX=15, HALF_MAX=7; send 0x55, stop high → oRX_VALID one cycle, oRX_DATA=0x55, oRX_FERR stays 0; pulse at 7+1+9*16 = 152 clk after T0.
- Back-to-back 0xA3 then 0x0F, no idle gap → two oRX_VALID pulses 160 clk apart, data 0xA3 then 0x0F.
- Low glitch of 4 clk on iRX → START aborts at HALF_MAX, returns to IDLE; no oRX_VALID, no oRX_FERR, oRX_BUSY high ≤ 9 clk.
- Frame 0xFF with stop bit low, line held low 50 more clk then high → one oRX_FERR pulse, oRX_DATA keeps previous value, state stays BREAK until rx_s high, then a following 0x3C frame is received correctly.
- reset asserted for 1 clk at data bit 4 of 0x81 → all outputs return to reset values; no pulse; next full frame 0x81 received normally.
- Line idle high 1000 clk after reset → oRX_BUSY 0, oRX_VALID 0, oRX_FERR 0, oRX_DATA 0x00 throughout.
